// File: rtl/regfile_sb.sv
// regfile_sb: 32x32 integer register file with a pending-write scoreboard and stall detection
module regfile_sb #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int REG_NUM = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] reg1_raddr_i,
   input  logic              reg1_re_i,
   output logic [DATA_W-1:0] reg1_rdata_o,
   input  logic [ADDR_W-1:0] reg2_raddr_i,
   input  logic              reg2_re_i,
   output logic [DATA_W-1:0] reg2_rdata_o,
   input  logic              issue_i,
   input  logic              issue_we_i,
   input  logic [ADDR_W-1:0] issue_waddr_i,
   input  logic              wb_we_i,
   input  logic [ADDR_W-1:0] wb_waddr_i,
   input  logic [DATA_W-1:0] wb_wdata_i,
   output logic              hazard_o
);
   logic [DATA_W-1:0]  r_regs [REG_NUM];
   logic [REG_NUM-1:0] r_pend;
   logic               w_wb_wr;
   logic               w_issue_set;
   logic               w_byp1;
   logic               w_byp2;
   logic               w_src1_stall;
   logic               w_src2_stall;

   assign w_wb_wr     = wb_we_i && (wb_waddr_i != '0);
   assign w_issue_set = issue_i && issue_we_i && (issue_waddr_i != '0);
   assign w_byp1      = wb_we_i && (wb_waddr_i == reg1_raddr_i);
   assign w_byp2      = wb_we_i && (wb_waddr_i == reg2_raddr_i);

   // register storage: write-back updates any register except x0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_NUM; i++) r_regs[i] <= '0;
      end else if (w_wb_wr) begin
         r_regs[wb_waddr_i] <= wb_wdata_i;
      end
   end

   // scoreboard: write-back clears, issue sets; the later assignment lets a same-address issue win
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend <= '0;
      end else begin
         if (w_wb_wr) r_pend[wb_waddr_i] <= 1'b0;
         if (w_issue_set) r_pend[issue_waddr_i] <= 1'b1;
      end
   end

   // read ports: disabled/x0 read zero, a same-cycle write-back is forwarded
   always_comb begin
      reg1_rdata_o = (!reg1_re_i || reg1_raddr_i == '0) ? '0 :
                     w_byp1 ? wb_wdata_i : r_regs[reg1_raddr_i];
      reg2_rdata_o = (!reg2_re_i || reg2_raddr_i == '0) ? '0 :
                     w_byp2 ? wb_wdata_i : r_regs[reg2_raddr_i];
   end

   // stall when an enabled non-zero source is pending and not being written back right now
   always_comb begin
      w_src1_stall = reg1_re_i && (reg1_raddr_i != '0) && r_pend[reg1_raddr_i] && !w_byp1;
      w_src2_stall = reg2_re_i && (reg2_raddr_i != '0) && r_pend[reg2_raddr_i] && !w_byp2;
      hazard_o     = w_src1_stall || w_src2_stall;
   end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed vector table, reset sequences and randomized model comparison for regfile_sb
module tb_regfile_sb;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  reg1_raddr_i = '0, reg2_raddr_i = '0, issue_waddr_i = '0, wb_waddr_i = '0;
   logic        reg1_re_i = 1'b0, reg2_re_i = 1'b0, issue_i = 1'b0, issue_we_i = 1'b0, wb_we_i = 1'b0;
   logic [31:0] wb_wdata_i = '0;
   logic [31:0] reg1_rdata_o, reg2_rdata_o;
   logic        hazard_o;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic        re1; logic [4:0] a1;
      logic        re2; logic [4:0] a2;
      logic        iss; logic iwe; logic [4:0] ia;
      logic        wwe; logic [4:0] wa; logic [31:0] wd;
      logic [31:0] e1; logic [31:0] e2; logic eh;
   } vec_t;

   vec_t vq[$];

   logic [31:0] m_regs [32];
   bit          m_pend [32];

   regfile_sb dut (
      .clk(clk), .rst_n(rst_n),
      .reg1_raddr_i(reg1_raddr_i), .reg1_re_i(reg1_re_i), .reg1_rdata_o(reg1_rdata_o),
      .reg2_raddr_i(reg2_raddr_i), .reg2_re_i(reg2_re_i), .reg2_rdata_o(reg2_rdata_o),
      .issue_i(issue_i), .issue_we_i(issue_we_i), .issue_waddr_i(issue_waddr_i),
      .wb_we_i(wb_we_i), .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i),
      .hazard_o(hazard_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic re1, input logic [4:0] a1, input logic re2, input logic [4:0] a2,
                      input logic iss, input logic [4:0] ia, input logic wwe, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [31:0] e1, input logic [31:0] e2, input logic eh);
      vec_t v;
      v.re1 = re1; v.a1 = a1; v.re2 = re2; v.a2 = a2;
      v.iss = iss; v.iwe = iss; v.ia = ia;
      v.wwe = wwe; v.wa = wa; v.wd = wd;
      v.e1 = e1; v.e2 = e2; v.eh = eh;
      vq.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      reg1_re_i = v.re1; reg1_raddr_i = v.a1;
      reg2_re_i = v.re2; reg2_raddr_i = v.a2;
      issue_i = v.iss; issue_we_i = v.iwe; issue_waddr_i = v.ia;
      wb_we_i = v.wwe; wb_waddr_i = v.wa; wb_wdata_i = v.wd;
   endtask

   task automatic idle();
      vec_t v;
      v = '{default: '0};
      drive(v);
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = '0;
         m_pend[i] = 1'b0;
      end
   endtask

   function automatic logic [31:0] m_read(input logic re, input logic [4:0] a, input vec_t v);
      if (!re || a == 0) return '0;
      if (v.wwe && v.wa == a) return v.wd;
      return m_regs[a];
   endfunction

   function automatic logic m_stall(input logic re, input logic [4:0] a, input vec_t v);
      return re && a != 0 && m_pend[a] && !(v.wwe && v.wa == a);
   endfunction

   initial begin
      vec_t v;
      // directed table: applied back to back from reset, state carries between rows
      add(1, 5, 1, 5, 0, 0, 0, 0, 0,            0,            0, 0);
      add(1, 3, 0, 0, 0, 0, 1, 3, 32'h12345678, 32'h12345678, 0, 0);
      add(1, 3, 0, 3, 0, 0, 0, 0, 0,            32'h12345678, 0, 0);
      add(1, 0, 1, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 0,            0, 0);
      add(1, 0, 1, 0, 0, 0, 0, 0, 0,            0,            0, 0);
      add(0, 3, 1, 3, 0, 0, 0, 0, 0,            0,            32'h12345678, 0);
      add(1, 3, 1, 7, 0, 0, 1, 7, 32'hA5A5A5A5, 32'h12345678, 32'hA5A5A5A5, 0);
      add(0, 0, 1, 7, 0, 0, 0, 0, 0,            0,            32'hA5A5A5A5, 0);
      add(1, 9, 0, 0, 1, 9, 0, 0, 0,            0,            0, 0);
      add(1, 9, 0, 0, 0, 0, 0, 0, 0,            0,            0, 1);
      add(1, 9, 0, 0, 0, 0, 1, 9, 32'h55,       32'h55,       0, 0);
      add(1, 9, 0, 0, 0, 0, 0, 0, 0,            32'h55,       0, 0);
      add(0, 0, 0, 0, 1, 4, 0, 0, 0,            0,            0, 0);
      add(0, 0, 1, 4, 0, 0, 0, 0, 0,            0,            0, 1);
      add(0, 0, 1, 4, 1, 4, 1, 4, 32'h11,       0,            32'h11, 0);
      add(0, 0, 1, 4, 0, 0, 0, 0, 0,            0,            32'h11, 1);
      add(1, 4, 1, 4, 0, 0, 1, 4, 32'h22,       32'h22,       32'h22, 0);
      add(1, 4, 0, 0, 0, 0, 0, 0, 0,            32'h22,       0, 0);
      add(1, 0, 1, 0, 1, 0, 0, 0, 0,            0,            0, 0);
      add(1, 0, 1, 0, 0, 0, 0, 0, 0,            0,            0, 0);

      do_reset();
      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         drive(vq[i]);
         #2;
         chk($sformatf("vec%0d rdata1", i), reg1_rdata_o, vq[i].e1);
         chk($sformatf("vec%0d rdata2", i), reg2_rdata_o, vq[i].e2);
         chk($sformatf("vec%0d hazard", i), {31'b0, hazard_o}, {31'b0, vq[i].eh});
      end

      // mid-run reset: x5 written and x6 pending, then an async reset must clear both
      @(negedge clk);
      idle();
      wb_we_i = 1; wb_waddr_i = 5; wb_wdata_i = 32'hDEADBEEF;
      issue_i = 1; issue_we_i = 1; issue_waddr_i = 6;
      @(negedge clk);
      idle();
      reg1_re_i = 1; reg1_raddr_i = 5; reg2_re_i = 1; reg2_raddr_i = 6;
      #2;
      chk("pre-reset x5", reg1_rdata_o, 32'hDEADBEEF);
      chk("pre-reset x6 hazard", {31'b0, hazard_o}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("async reset x5", reg1_rdata_o, 0);
      chk("async reset hazard", {31'b0, hazard_o}, 0);
      // write attempted on an edge while reset is held must be dropped
      @(negedge clk);
      wb_we_i = 1; wb_waddr_i = 5; wb_wdata_i = 32'h0BADF00D;
      @(negedge clk);
      idle();
      rst_n = 1'b1;
      reg1_re_i = 1; reg1_raddr_i = 5; reg2_re_i = 1; reg2_raddr_i = 5;
      #2;
      chk("post-reset x5 p1", reg1_rdata_o, 0);
      chk("post-reset x5 p2", reg2_rdata_o, 0);
      chk("post-reset hazard", {31'b0, hazard_o}, 0);
      reg2_raddr_i = 6;
      #1;
      chk("post-reset x6 hazard", {31'b0, hazard_o}, 0);

      // randomized traffic against the reference model
      do_reset();
      model_reset();
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         v.re1 = 1'($urandom_range(0, 3) != 0);
         v.re2 = 1'($urandom_range(0, 3) != 0);
         v.a1  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         v.a2  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         v.wwe = 1'($urandom_range(0, 2) == 0);
         v.wa  = 5'($urandom_range(0, 7));
         v.wd  = $urandom;
         v.eh  = m_stall(v.re1, v.a1, v) || m_stall(v.re2, v.a2, v);
         v.iss = !v.eh && ($urandom_range(0, 2) == 0);
         v.iwe = 1'($urandom_range(0, 3) != 0);
         v.ia  = 5'($urandom_range(0, 7));
         v.e1  = m_read(v.re1, v.a1, v);
         v.e2  = m_read(v.re2, v.a2, v);
         drive(v);
         #2;
         chk("rand rdata1", reg1_rdata_o, v.e1);
         chk("rand rdata2", reg2_rdata_o, v.e2);
         chk("rand hazard", {31'b0, hazard_o}, {31'b0, v.eh});
         if (v.wwe && v.wa != 0) begin
            m_regs[v.wa] = v.wd;
            m_pend[v.wa] = 1'b0;
         end
         if (v.iss && v.iwe && v.ia != 0) m_pend[v.ia] = 1'b1;
      end

      @(negedge clk);
      idle();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
